sort_net_seq: RTL and testbench
===============================

# sort_net_seq

Parametrised sequential sorter for N unsigned W-bit keys. It is the registered, handshaked successor to the team's 4×4-bit combinational compare-swap sorting network. It implements odd-even transposition sort, one phase per clock. It adds a runtime ascending/descending mode and early termination once the vector is sorted. It sits between a valid/ready producer and consumer and holds one vector at a time.

## Interface
- N, 4, number of keys; N ≥ 2.
- W, 4, key width in bits; W ≥ 1.
- PW, $clog2(N+1), width of the phase-count output (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  producer has a vector.
- in_ready  output  1  block accepts a vector.
- in_data  input  N*W  keys; element 0 = in_data[N*W-1 -: W] (most significant slice), element k = in_data[(N-k)*W-1 -: W].
- desc  input  1  mode, sampled on accept: 1 = element 0 largest, 0 = element 0 smallest.
- out_valid  output  1  sorted vector available.
- out_ready  input  1  consumer takes the vector.
- out_data  output  N*W  sorted keys, same element ordering as in_data.
- out_phases  output  PW  number of phases executed for the current result.

## Operation
- FSM states: IDLE, SORT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load the vector register from in_data, latch desc, clear the phase counter k and the prev_noswap flag, then go to SORT.
- SORT:
  - Each cycle executes phase k.
  - Even k compares pairs (0,1), (2,3), …; odd k compares pairs (1,2), (3,4), ….
  - For a pair (j, j+1) with desc = 1, swap when elem[j] < elem[j+1]. With desc = 0, swap when elem[j] > elem[j+1]. Comparison is strict and unsigned, so equal keys are never swapped.
  - A key left unpaired at either end holds its value.
  - noswap = no pair swapped in phase k.
  - Terminate after phase k when (k ≥ 1 and noswap and prev_noswap) or k = N-1. On termination, go to DONE and set out_phases = k+1.
  - Otherwise set prev_noswap ← noswap, k ← k+1, and stay in SORT.
- DONE:
  - out_valid = 1; out_data and out_phases are held stable.
  - When out_ready = 1, go to IDLE.
- in_ready = 0 in SORT and DONE; in_valid is ignored there.
- out_data always reflects the vector register.
- out_valid is decoded from the state only (no combinational path from inputs to outputs).
- Reset (asynchronous, any state, including mid-SORT): state = IDLE, vector register = 0, out_data = 0, out_phases = 0, out_valid = 0, in_ready = 1 once nrst is released. The partially sorted vector is discarded.

## Timing
- Accept occurs at rising edge T, when in_valid & in_ready.
- Phase i (0-based) completes at edge T+1+i.
- out_valid rises after edge T+P, where P = out_phases, with 2 ≤ P ≤ N.
- Worst-case latency is N cycles from accept to out_valid; best case is 2.
- Consumer handshake: out_valid & out_ready at edge U moves the block to IDLE. in_ready is 1 after U, so the next accept is possible at U+1.
- Maximum throughput is one vector per P+2 cycles.
- out_valid stays high, with out_data and out_phases unchanged, for any number of cycles while out_ready = 0.

## Test plan
- N=4, W=4, desc=1, in_data=16'h1234 → out_data=16'h4321, out_phases=4, out_valid rises 4 edges after accept.
- desc=1, in_data=16'h4321 (already sorted) → out_data=16'h4321, out_phases=2.
- desc=0, in_data=16'h4321 → out_data=16'h1234, out_phases=4; and in_data=16'h7777 → 16'h7777, out_phases=2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with 16'hABCD → out_valid and out_data stay constant, in_ready=0, no second accept. Then raise out_ready → IDLE, and accept 16'hABCD on the next edge.
- Reset mid-SORT: assert nrst=0 after phase 1 of 16'h1234 → out_data=0, out_phases=0, out_valid=0 immediately (no clock needed), in_ready=1 after release.
- Randomised, N=8, W=6, both modes, back-to-back vectors → out_data matches a reference sort, 2 ≤ out_phases ≤ 8, and no lost or duplicated vectors.

Source files
------------

// File: rtl/sort_net_seq.sv
// sort_net_seq
// Sequential odd-even transposition sorter for N unsigned W-bit keys.
// One vector is held at a time. Each clock in SORT runs one phase. A runtime
// mode picks the order (desc=1: element 0 largest). The sort stops early once
// two phases in a row swap nothing, or after N phases at most.
//
// Ports:
//   clk         rising-edge clock
//   nrst        asynchronous active-low reset
//   in_valid    producer offers a vector on in_data
//   in_ready    block can accept a vector (IDLE only)
//   in_data     N keys, element 0 in the most significant W bits
//   desc        sort order, sampled on accept
//   out_valid   sorted vector available (DONE only)
//   out_ready   consumer takes the vector
//   out_data    vector register, same element ordering as in_data
//   out_phases  number of phases executed for the current result
//   dbg_state   current FSM state (0 IDLE, 1 SORT, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready and out_valid are decoded from the state register only.
// Neither depends combinationally on in_valid or out_ready.
module sort_net_seq #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int PW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic            desc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [PW-1:0]   out_phases,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SORT = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q;
  logic [N*W-1:0]  vec_q;
  logic            desc_q;
  logic [PW-1:0]   k_q;
  logic [PW-1:0]   phases_q;
  logic            prev_noswap_q;

  logic [W-1:0]    elem [N];
  logic [W-1:0]    nxt_elem [N];
  logic [N*W-1:0]  nxt_vec;
  logic            noswap;
  logic            last;

  // One compare-swap phase on the held vector. Pairs start at index 0 on
  // even phases and at index 1 on odd phases. Pairs never overlap, so every
  // comparison reads the pre-phase values. Keys left unpaired keep their value.
  always_comb begin
    nxt_vec = '0;
    noswap  = 1'b1;
    for (int i = 0; i < N; i++) begin
      elem[i]     = vec_q[(N-i)*W-1 -: W];
      nxt_elem[i] = vec_q[(N-i)*W-1 -: W];
    end
    for (int j = 0; j < N - 1; j++) begin
      if ((j & 1) == int'(k_q[0])) begin
        if (desc_q ? (elem[j] < elem[j+1]) : (elem[j] > elem[j+1])) begin
          nxt_elem[j]   = elem[j+1];
          nxt_elem[j+1] = elem[j];
          noswap        = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      nxt_vec[(N-i)*W-1 -: W] = nxt_elem[i];
    end
  end

  // Two quiet phases in a row (odd and even) mean that every adjacent pair is
  // already ordered. N phases always finish the sort.
  assign last = ((k_q != '0) && noswap && prev_noswap_q) || (k_q == PW'(N - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      vec_q         <= '0;
      desc_q        <= 1'b0;
      k_q           <= '0;
      phases_q      <= '0;
      prev_noswap_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q         <= in_data;
            desc_q        <= desc;
            k_q           <= '0;
            prev_noswap_q <= 1'b0;
            state_q       <= SORT;
          end
        end
        SORT: begin
          vec_q <= nxt_vec;
          if (last) begin
            phases_q <= k_q + PW'(1);
            state_q  <= DONE;
          end else begin
            prev_noswap_q <= noswap;
            k_q           <= k_q + PW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_data   = vec_q;
  assign out_phases = phases_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sort_net_seq.sv
// Bench for sort_net_seq: directed N=4/W=4 cases, then randomised N=8/W=6
// back-to-back vectors checked against a reference sort.
module tb_sort_net_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N=4, W=4 instance ----------------
  logic        in_valid4 = 1'b0, in_ready4, desc4 = 1'b0;
  logic        out_valid4, out_ready4 = 1'b0;
  logic [15:0] in_data4 = '0, out_data4;
  logic [2:0]  out_phases4;
  logic [1:0]  dbg_state4;

  sort_net_seq #(.N(4), .W(4)) u_dut4 (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .desc(desc4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_phases(out_phases4), .dbg_state(dbg_state4)
  );

  // ---------------- N=8, W=6 instance ----------------
  logic        in_valid8 = 1'b0, in_ready8, desc8 = 1'b0;
  logic        out_valid8, out_ready8 = 1'b1;
  logic [47:0] in_data8 = '0, out_data8;
  logic [3:0]  out_phases8;
  logic [1:0]  dbg_state8;

  sort_net_seq #(.N(8), .W(6)) u_dut8 (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .desc(desc8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_phases(out_phases8), .dbg_state(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int hs8 = 0;
  logic [47:0] exp_q[$];
  int          exp_p_q[$];

  always @(posedge clk) if (nrst && out_valid8 && out_ready8) hs8++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the sorted result comes from a queue sort; the phase count
  // comes from applying the transposition phases to a plain array until the
  // stop rule (two quiet phases in a row, or N phases) is met.
  function automatic void ref_sort(input int n, input int w, input logic [63:0] data,
                                   input bit d, output logic [63:0] sorted, output int phases);
    int q[$];
    int a[16];
    int t;
    bit noswap, prev;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    for (int k = 0; k < n; k++) begin
      a[k] = int'((data >> ((n - 1 - k) * w)) & mask);
      q.push_back(a[k]);
    end
    if (d) q.rsort(); else q.sort();
    sorted = '0;
    for (int k = 0; k < n; k++) sorted = (sorted << w) | 64'(q[k]);
    phases = 0;
    prev = 1'b0;
    for (int k = 0; k < n; k++) begin
      noswap = 1'b1;
      for (int j = k % 2; j + 1 < n; j += 2) begin
        if (d ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          noswap = 1'b0;
        end
      end
      if ((k >= 1 && noswap && prev) || k == n - 1) begin
        phases = k + 1;
        break;
      end
      prev = noswap;
    end
  endfunction

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  // Accept a vector on the N=4 block and wait for its result.
  task automatic start4(input logic [15:0] data, input bit d, input logic [15:0] exp_d,
                        input int exp_p, input string tag);
    int lat;
    in_data4 = data; desc4 = d; in_valid4 = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready4), 64'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, 64'(out_valid4), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_p));
    check({tag, "_data"}, 64'(out_data4), 64'(exp_d));
    check({tag, "_phases"}, 64'(out_phases4), 64'(exp_p));
  endtask

  task automatic release4(input string tag);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid4), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready4), 64'd1);
  endtask

  // Offer one vector to the N=8 block, wait for the accept, then its result.
  task automatic send8(input logic [47:0] data, input bit d);
    logic [63:0] s;
    int p, lat;
    bit acc;
    in_data8 = data; desc8 = d; in_valid8 = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      if (in_ready8) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    check("rand_accept", 64'(acc), 64'd1);
    ref_sort(8, 6, 64'(data), d, s, p);
    exp_q.push_back(s[47:0]);
    exp_p_q.push_back(p);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rand_valid", 64'(out_valid8), 64'd1);
    if (exp_q.size() > 0) begin
      check("rand_data", 64'(out_data8), 64'(exp_q.pop_front()));
      p = exp_p_q.pop_front();
      check("rand_phases", 64'(out_phases8), 64'(p));
      check("rand_latency", 64'(lat), 64'(p));
      check("rand_phase_range", 64'(out_phases8 >= 2 && out_phases8 <= 8), 64'd1);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [63:0] s;
    int p;

    #3;
    check("reset_valid", 64'(out_valid4), 64'd0);
    check("reset_ready", 64'(in_ready4), 64'd1);
    check("reset_data", 64'(out_data4), 64'd0);
    check("reset_phases", 64'(out_phases4), 64'd0);
    #9 nrst = 1'b1;
    @(posedge clk); #1;

    start4(16'h1234, 1'b1, 16'h4321, 4, "desc_rev");   release4("desc_rev");
    start4(16'h4321, 1'b1, 16'h4321, 2, "desc_sorted"); release4("desc_sorted");
    start4(16'h4321, 1'b0, 16'h1234, 4, "asc_rev");    release4("asc_rev");
    start4(16'h7777, 1'b0, 16'h7777, 2, "asc_equal");  release4("asc_equal");

    // Backpressure: result held while out_ready=0, in_valid pulses ignored.
    start4(16'h1234, 1'b1, 16'h4321, 4, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid4 = (i % 2 == 0);
      in_data4  = 16'hABCD;
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid4), 64'd1);
      check("bp_hold_data", 64'(out_data4), 64'h4321);
      check("bp_hold_phases", 64'(out_phases4), 64'd4);
      check("bp_no_ready", 64'(in_ready4), 64'd0);
    end
    in_valid4 = 1'b1; in_data4 = 16'hABCD; desc4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("bp_release_valid", 64'(out_valid4), 64'd0);
    check("bp_release_ready", 64'(in_ready4), 64'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("bp_accept", 64'(in_ready4), 64'd0);
    ref_sort(4, 4, 64'h0ABCD, 1'b1, s, p);
    begin
      int lat;
      lat = 0;
      while (!out_valid4 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("bp2_valid", 64'(out_valid4), 64'd1);
      check("bp2_latency", 64'(lat), 64'(p));
      check("bp2_data", 64'(out_data4), s);
      check("bp2_phases", 64'(out_phases4), 64'(p));
    end
    release4("bp2");

    // Reset in the middle of a sort, after phase 1.
    in_data4 = 16'h1234; desc4 = 1'b1; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    check("rst_mid_data", 64'(out_data4), 64'd0);
    check("rst_mid_phases", 64'(out_phases4), 64'd0);
    check("rst_mid_valid", 64'(out_valid4), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_after", 64'(in_ready4), 64'd1);
    check("rst_valid_after", 64'(out_valid4), 64'd0);

    // Randomised N=8 vectors, both modes, back to back with out_ready held high.
    for (int v = 0; v < 40; v++) begin
      logic [47:0] d;
      d = {16'($urandom), 32'($urandom)};
      send8(d, 1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;
    check("rand_handshakes", 64'(hs8), 64'd40);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
